// File: rtl/fxp_pkg.sv
// Shared definitions for the sign-magnitude Q15 arithmetic units
// (multiplier and iterative divider use identical format and handshake).
package fxp_pkg;

  // Word format: bit N-1 is the sign, bits N-2:0 are the magnitude,
  // and the low Q bits of the magnitude are fractional.
  localparam int N = 27;
  localparam int Q = 15;

  // Iteration counter width, sized to count magnitude bits.
  localparam int CNT_W = $clog2(N);

  // Controller state encoding, common to both arithmetic units.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Width of the double-length product datapath.
  localparam int PW = 2 * (N - 1);

endpackage

// File: rtl/fxp_mul.sv
// Sequential sign-magnitude Q15 multiplier, radix-2 shift-add.
// One multiplier magnitude bit is consumed per clock, then a finalize
// cycle rescales by Q, range-checks and publishes the product.
module fxp_mul
  import fxp_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_result,
  output logic         o_complete,
  output logic         o_overflow
);

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [N-2:0]     mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             sign_q,   sign_d;
  logic [N-1:0]     result_q, result_d;
  logic             cmp_q,    cmp_d;
  logic             ovf_q,    ovf_d;

  // Next-state and datapath: latch operands, iterate shift-add, finalize.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // Magnitudes right-aligned; sign is the XOR of operand signs.
          mcand_d  = {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
          mplier_d = i_multiplier[N-2:0];
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = i_multiplicand[N-1] ^ i_multiplier[N-1];
          ovf_d    = 1'b0;
          cmp_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Double-length accumulator cannot wrap on any partial sum.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N-2)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        // Drop Q fraction bits (truncate toward zero); anything above
        // the magnitude field is an overflow, low bits still written.
        // Sign kept even for a zero magnitude to match the divider.
        result_d = {sign_q, acc_q[N-2+Q:Q]};
        ovf_d    = |acc_q[PW-1:N-1+Q];
        cmp_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cmp_d   = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      cmp_q    <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_result   = result_q;
  assign o_complete = cmp_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fxp_mul.sv
// Bench for fxp_mul: cycle-level reference model with a per-cycle
// compare, plus directed operations with hand-computed results.
module tb_fxp_mul;
  localparam int N = 27;
  localparam int Q = 15;
  localparam int LAT = N;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [N-1:0] i_multiplicand = '0;
  logic [N-1:0] i_multiplier = '0;
  logic         i_start = 1'b0;
  logic [N-1:0] o_result;
  logic         o_complete;
  logic         o_overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  fxp_mul dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
    .i_start(i_start), .o_result(o_result),
    .o_complete(o_complete), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Product from plain integer arithmetic: {overflow, result}.
  function automatic logic [N:0] mdl(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned p, sh;
    logic [N-2:0] mag;
    p   = longint'(a[N-2:0]) * longint'(b[N-2:0]);
    sh  = p >> Q;
    mag = sh[N-2:0];
    return {((sh >> (N-1)) != 0), a[N-1] ^ b[N-1], mag};
  endfunction

  // Reference: busy countdown, operands captured at acceptance.
  int           m_busy = 0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_ovf = 1'b0;
  logic [N:0]   m_tmp;
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_busy = 0; m_res = '0; m_ovf = 1'b0;
    end else if (m_busy == 0) begin
      if (i_start) begin
        m_a = i_multiplicand; m_b = i_multiplier; m_busy = LAT; m_ovf = 1'b0;
      end
    end else begin
      m_busy = m_busy - 1;
      if (m_busy == 0) begin
        m_tmp = mdl(m_a, m_b);
        m_res = m_tmp[N-1:0];
        m_ovf = m_tmp[N];
      end
    end
  end

  // Every cycle: outputs must match the reference.
  always @(negedge i_clk) begin
    if (chk_en) begin
      checks++;
      if (o_complete !== (m_busy == 0) || o_result !== m_res || o_overflow !== m_ovf) begin
        errors++;
        $display("FAIL model t=%0t: got cmp=%b res=%h ovf=%b, want cmp=%b res=%h ovf=%b",
                 $time, o_complete, o_result, o_overflow, (m_busy == 0), m_res, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Start one op, count busy cycles, check final result.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_res, input logic exp_ovf);
    int cyc = 0;
    @(negedge i_clk);
    i_multiplicand = a; i_multiplier = b; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_multiplicand = ~a; i_multiplier = ~b;   // must not affect result
    while (!o_complete && cyc < 200) begin
      cyc++;
      @(negedge i_clk);
    end
    chk({name, "_busy"}, cyc, LAT);
    chk({name, "_res"}, o_result, exp_res);
    chk({name, "_ovf"}, o_overflow, exp_ovf);
  endtask

  initial begin
    logic [N:0] pin;
    // Pin the model itself against hand values.
    pin = mdl(27'h000C000, 27'h0010000); chk("mdl_mul", pin, {1'b0, 27'h0018000});
    pin = mdl(27'h2000000, 27'h0010000); chk("mdl_ovf", pin, {1'b1, 27'h0000000});
    pin = mdl(27'h400C000, 27'h400C000); chk("mdl_sgn", pin, {1'b0, 27'h0012000});

    // Reset and idle.
    repeat (3) @(negedge i_clk);
    chk("rst_cmp", o_complete, 1);
    chk("rst_res", o_result, 0);
    chk("rst_ovf", o_overflow, 0);
    i_start = 1'b1; i_multiplicand = 27'h000C000; i_multiplier = 27'h0010000;
    @(negedge i_clk);
    i_start = 1'b0; i_rst = 1'b0;
    chk("rst_start_cmp", o_complete, 1);
    chk_en = 1'b1;
    @(negedge i_clk);
    chk("idle_cmp", o_complete, 1);

    run_op("mul", 27'h000C000, 27'h0010000, 27'h0018000, 1'b0);
    run_op("neg", 27'h400C000, 27'h0010000, 27'h4018000, 1'b0);
    run_op("negneg", 27'h400C000, 27'h400C000, 27'h0012000, 1'b0);
    run_op("negzero", 27'h0000000, 27'h4028000, 27'h4000000, 1'b0);
    run_op("trunc1", 27'h0000003, 27'h0008000, 27'h0000003, 1'b0);
    run_op("trunc2", 27'h0000001, 27'h0004000, 27'h0000000, 1'b0);
    run_op("ovf", 27'h2000000, 27'h0010000, 27'h0000000, 1'b1);
    run_op("ovfclr", 27'h0008000, 27'h0008000, 27'h0008000, 1'b0);

    // Start while busy is ignored.
    @(negedge i_clk);
    i_multiplicand = 27'h000C000; i_multiplier = 27'h0010000; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_multiplicand = 27'h0008000; i_multiplier = 27'h0008000; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (LAT) @(negedge i_clk);
    chk("busy_ign_cmp", o_complete, 1);
    chk("busy_ign_res", o_result, 27'h0018000);

    // Reset mid-operation aborts.
    i_multiplicand = 27'h400C000; i_multiplier = 27'h0010000; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("abort_busy", o_complete, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_cmp", o_complete, 1);
    chk("abort_res", o_result, 0);
    run_op("fresh", 27'h400C000, 27'h0010000, 27'h4018000, 1'b0);

    // Start held high: back-to-back ops with one idle cycle between,
    // timing covered by the per-cycle model compare.
    @(negedge i_clk);
    i_multiplicand = 27'h0010000; i_multiplier = 27'h0010000; i_start = 1'b1;
    repeat (2 * LAT + 3) @(negedge i_clk);
    i_start = 1'b0;
    repeat (LAT + 2) @(negedge i_clk);
    chk("b2b_res", o_result, 27'h0020000);
    chk("b2b_cmp", o_complete, 1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
